// File: rtl/fifo_wr_cntrl.sv
// Packet router front end: decodes the header beat, forwards the packet to one of
// NUM_SW_INST FIFOs or discards it. Define FIFO_WR_DROP_CNT_EN to enable drop_cnt.
module fifo_wr_cntrl #(
    parameter int                 NUM_SW_INST = 5,
    parameter int                 W_WIDTH     = 8,
    parameter logic [W_WIDTH-1:0] BASE_ADDR   = 8'h10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W_WIDTH-1:0]     data_in,
    input  logic                   valid_in,
    input  logic                   last_in,
    output logic                   ready_out,
    input  logic [NUM_SW_INST-1:0] full,
    output logic [NUM_SW_INST-1:0] wr_en,
    output logic [W_WIDTH-1:0]     wr_data,
    output logic                   wr_last,
    output logic [7:0]             drop_cnt
);

    localparam int                 SEL_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
    localparam logic [W_WIDTH-1:0] NUM_W = W_WIDTH'(NUM_SW_INST);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                 state, state_nxt;
    logic [SEL_W-1:0]       sel_ff, sel_cur;
    logic [W_WIDTH-1:0]     offset;
    logic                   in_range;
    logic                   rdy;
    logic                   fwd_beat;
    logic [NUM_SW_INST-1:0] wr_en_nxt;

    // Offset form of the range test avoids overflow of BASE_ADDR+NUM_SW_INST-1.
    assign offset    = data_in - BASE_ADDR;
    assign in_range  = (data_in >= BASE_ADDR) && (offset < NUM_W);
    assign sel_cur   = (state == IDLE) ? offset[SEL_W-1:0] : sel_ff;
    assign ready_out = rdy;

    always_comb begin
        state_nxt = state;
        rdy       = 1'b1;
        fwd_beat  = 1'b0;
        wr_en_nxt = '0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (in_range) begin
                        rdy = ~full[sel_cur];
                        if (rdy) begin
                            fwd_beat  = 1'b1;
                            state_nxt = last_in ? IDLE : FWD;
                        end
                    end else begin
                        state_nxt = last_in ? IDLE : DROP;
                    end
                end
            end
            FWD: begin
                rdy = ~full[sel_ff];
                if (valid_in && rdy) begin
                    fwd_beat = 1'b1;
                    if (last_in) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (valid_in && last_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (fwd_beat) wr_en_nxt[sel_cur] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_ff  <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            wr_last <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= wr_en_nxt;
            if (fwd_beat) begin
                wr_data <= data_in;
                wr_last <= last_in;
                if (state == IDLE) sel_ff <= sel_cur;
            end
        end
    end

`ifdef FIFO_WR_DROP_CNT_EN
    logic drop_hdr;

    // Out-of-range headers are always accepted, so a header seen is a packet dropped.
    assign drop_hdr = (state == IDLE) && valid_in && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_hdr && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_cntrl.sv
// Directed self-checking bench for fifo_wr_cntrl (NUM_SW_INST=5, W_WIDTH=8, BASE_ADDR=8'h10).
module tb_fifo_wr_cntrl;

`ifdef FIFO_WR_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       last_in;
    logic       ready_out;
    logic [4:0] full;
    logic [4:0] wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic [7:0] drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_wr_cntrl #(
        .NUM_SW_INST(5),
        .W_WIDTH    (8),
        .BASE_ADDR  (8'h10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .last_in  (last_in),
        .ready_out(ready_out),
        .full     (full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic l);
        valid_in = v;
        data_in  = d;
        last_in  = l;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat, check ready, clock it, then check the registered write.
    task automatic beat(input string tag, input logic [7:0] d, input logic l,
                        input logic exp_rdy, input logic [4:0] exp_wr);
        set_in(1'b1, d, l);
        chk({tag, "_rdy"}, 32'(ready_out), 32'(exp_rdy));
        tick;
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_wr));
        if (exp_wr != 5'b0) begin
            chk({tag, "_wr_data"}, 32'(wr_data), 32'(d));
            chk({tag, "_wr_last"}, 32'(wr_last), 32'(l));
        end
    endtask

    function automatic logic [7:0] exp_cnt(input logic [7:0] v);
        return CNT_EN ? v : 8'h00;
    endfunction

    initial begin
        rst_n    = 1'b0;
        full     = '0;
        valid_in = 1'b0;
        data_in  = '0;
        last_in  = 1'b0;
        #2;
        chk("rst_wr_en",    32'(wr_en),     32'h0);
        chk("rst_wr_data",  32'(wr_data),   32'h0);
        chk("rst_wr_last",  32'(wr_last),   32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt),  32'h0);
        chk("rst_ready",    32'(ready_out), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Three-beat packet to port 0
        beat("p0_hdr", 8'h10, 1'b0, 1'b1, 5'b00001);
        beat("p0_b1",  8'hAA, 1'b0, 1'b1, 5'b00001);
        beat("p0_b2",  8'hBB, 1'b1, 1'b1, 5'b00001);
        set_in(1'b0, 8'h00, 1'b0);
        chk("idle_ready", 32'(ready_out), 32'h1);
        tick;
        chk("idle_wr_en", 32'(wr_en), 32'h0);

        // Header to port 4 stalls while full[4]; other bits toggle freely
        full = 5'b10000;
        beat("p4_stall0", 8'h14, 1'b0, 1'b0, 5'b00000);
        full = 5'b10101;
        beat("p4_stall1", 8'h14, 1'b0, 1'b0, 5'b00000);
        full = 5'b11010;
        beat("p4_stall2", 8'h14, 1'b0, 1'b0, 5'b00000);
        full = 5'b01111;
        beat("p4_hdr",    8'h14, 1'b0, 1'b1, 5'b10000);
        full = 5'b10000;
        beat("p4_midstall", 8'h55, 1'b1, 1'b0, 5'b00000);
        full = 5'b01111;
        beat("p4_last",   8'h55, 1'b1, 1'b1, 5'b10000);
        full = '0;

        // Out-of-range packets are discarded even with every FIFO full
        full = 5'b11111;
        beat("drop_hdr20", 8'h20, 1'b0, 1'b1, 5'b00000);
        chk("drop_cnt_1a", 32'(drop_cnt), 32'(exp_cnt(8'h01)));
        beat("drop_b1",    8'h12, 1'b0, 1'b1, 5'b00000);
        beat("drop_b2",    8'h13, 1'b1, 1'b1, 5'b00000);
        chk("drop_cnt_1b", 32'(drop_cnt), 32'(exp_cnt(8'h01)));
        beat("drop_hdr0F", 8'h0F, 1'b1, 1'b1, 5'b00000);
        chk("drop_cnt_2",  32'(drop_cnt), 32'(exp_cnt(8'h02)));
        beat("drop_hdr15", 8'h15, 1'b1, 1'b1, 5'b00000);
        chk("drop_cnt_3",  32'(drop_cnt), 32'(exp_cnt(8'h03)));
        full = '0;

        // Back-to-back packets, no bubble
        beat("b2b_hdr12", 8'h12, 1'b0, 1'b1, 5'b00100);
        beat("b2b_b01",   8'h01, 1'b1, 1'b1, 5'b00100);
        beat("b2b_hdr13", 8'h13, 1'b1, 1'b1, 5'b01000);

        // Reset in the middle of a packet to port 1
        beat("rst_hdr11", 8'h11, 1'b0, 1'b1, 5'b00010);
        beat("rst_bA1",   8'hA1, 1'b0, 1'b1, 5'b00010);
        set_in(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",    32'(wr_en),    32'h0);
        chk("mid_rst_wr_data",  32'(wr_data),  32'h0);
        chk("mid_rst_wr_last",  32'(wr_last),  32'h0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        full = 5'b00001;
        beat("post_rst_hdr11", 8'h11, 1'b0, 1'b1, 5'b00010);
        beat("post_rst_last",  8'h77, 1'b1, 1'b1, 5'b00010);
        full = '0;

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, 8'hFF, 1'b1);
            tick;
            if (i == 253) chk("drop_cnt_254", 32'(drop_cnt), 32'(exp_cnt(8'hFE)));
            if (i == 254) chk("drop_cnt_255", 32'(drop_cnt), 32'(exp_cnt(8'hFF)));
        end
        chk("drop_cnt_sat",  32'(drop_cnt), 32'(exp_cnt(8'hFF)));
        chk("drop_no_wr_en", 32'(wr_en),    32'h0);
        set_in(1'b0, 8'h00, 1'b0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_cntrl.md
FIFO_WR_CNTRL -- requirements
Module: fifo_wr_cntrl

Interface
REQ-001 SHALL provide parameter NUM_SW_INST, default 5, number of destination FIFOs/switch instances.
REQ-002 SHALL provide parameter W_WIDTH, default 8, data beat width.
REQ-003 SHALL provide parameter BASE_ADDR, default 8'h10, address of destination 0; destination k at BASE_ADDR+k.
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have data_in  input  W_WIDTH  incoming packet beat; the first beat of a packet is the header (address).
REQ-007 SHALL have valid_in  input  1  data_in valid.
REQ-008 SHALL have last_in  input  1  marks the final beat of a packet.
REQ-009 SHALL have ready_out  output  1  beat accepted when valid_in && ready_out.
REQ-010 SHALL have full  input  NUM_SW_INST  per-FIFO almost-full, asserted when at most one free slot remains.
REQ-011 SHALL have wr_en  output  NUM_SW_INST  one-hot FIFO write strobe.
REQ-012 SHALL have wr_data  output  W_WIDTH  data written to the selected FIFO.
REQ-013 SHALL have wr_last  output  1  last flag stored alongside wr_data.
REQ-014 SHALL have drop_cnt  output  8  count of dropped packets.

Function
REQ-015 SHALL implement states IDLE (await header), FWD (forward beats to the selected FIFO) and DROP (discard the rest of the packet).
REQ-016 In IDLE with valid_in: addr = data_in; in range iff BASE_ADDR <= addr <= BASE_ADDR+NUM_SW_INST-1; sel = addr-BASE_ADDR, latched in a register.
REQ-017 IDLE, in-range header: ready_out = ~full[sel]; on accept, write the header beat to FIFO sel; next state FWD, or IDLE if last_in.
REQ-018 IDLE, out-of-range header: ready_out = 1; beat discarded; next state DROP, or IDLE if last_in; the packet counts as dropped.
REQ-019 FWD: ready_out = ~full[sel_ff]; each accepted beat is written to FIFO sel_ff; the beat with last_in returns to IDLE.
REQ-020 DROP: ready_out = 1; all beats discarded; the beat with last_in returns to IDLE.
REQ-021 IDLE with valid_in = 0: ready_out = 1, no state change.
REQ-022 wr_en, wr_data and wr_last SHALL be registered: one-cycle latency from the accept edge; wr_en = 0 in every cycle after an edge with no accepted forwarded beat.
REQ-023 wr_en SHALL be one-hot or zero; it is never asserted for a discarded beat.
REQ-024 Back-to-back packets SHALL be supported without a bubble: the header of packet N+1 may be accepted in the cycle after the last beat of packet N.
REQ-025 full[sel] rising mid-packet SHALL stall (ready_out = 0) without losing or duplicating beats; forwarding resumes the cycle full deasserts.
REQ-026 full bits of non-selected FIFOs SHALL be ignored.
REQ-027 drop_cnt SHALL increment by 1 per dropped packet, saturating at 8'hFF.

Reset
REQ-028 On rst_n low: state = IDLE, sel_ff = 0, wr_en = 0, wr_data = 0, wr_last = 0, drop_cnt = 0, immediately and asynchronously.
REQ-029 Reset mid-packet SHALL abandon the packet; the first valid beat after reset release is treated as a header.

Configuration
REQ-030 With macro FIFO_WR_DROP_CNT_EN defined: drop_cnt behaves per REQ-027.
REQ-031 Without FIFO_WR_DROP_CNT_EN: no counter register; drop_cnt tied to 0; all other behaviour identical.

Verification (NUM_SW_INST=5, W_WIDTH=8, BASE_ADDR=8'h10)
REQ-032 Packet 10,AA,BB (last on BB), full = 0 -> wr_en = 5'b00001 for 3 consecutive cycles with data 10,AA,BB and wr_last = 1 only with BB; returns to IDLE.
REQ-033 Header 14 with full[4] = 1 for 3 cycles -> ready_out = 0 for 3 cycles, no wr_en; header accepted after full drops; other full bits toggling have no effect.
REQ-034 Header 20, then 2 beats with last -> ready_out = 1 throughout, wr_en stays 0, drop_cnt 0->1; a single-beat header 0F with last -> drop_cnt = 2.
REQ-035 Back-to-back packets 12,01(last) and 13(last) -> wr_en 00100, 00100, 01000 in consecutive cycles.
REQ-036 rst_n low after beat 2 of a 4-beat packet to port 1 -> outputs zero at once; after release, beat 11 is decoded as a header to port 1.
REQ-037 With FIFO_WR_DROP_CNT_EN: 300 dropped packets -> drop_cnt = FF; without the macro -> drop_cnt = 0.
